// File: rtl/alert_handler_esc_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : alert_handler_esc_tx_if
// Brief    : Escalation lane bundle between the alert handler core and sender.
// Revision : 1.0
// ============================================================================
interface alert_handler_esc_tx_if;
    logic esc_en_i;
    logic ping_en_i;
    logic esc_rx_p_i;
    logic esc_rx_n_i;
    logic esc_tx_p_o;
    logic esc_tx_n_o;
    logic ping_ok_o;
    logic integ_fail_o;

    // master: alert handler core side; slave: escalation sender
    modport master (
        output esc_en_i,
        output ping_en_i,
        output esc_rx_p_i,
        output esc_rx_n_i,
        input  esc_tx_p_o,
        input  esc_tx_n_o,
        input  ping_ok_o,
        input  integ_fail_o
    );

    modport slave (
        input  esc_en_i,
        input  ping_en_i,
        input  esc_rx_p_i,
        input  esc_rx_n_i,
        output esc_tx_p_o,
        output esc_tx_n_o,
        output ping_ok_o,
        output integ_fail_o
    );
endinterface
`default_nettype wire

// File: rtl/alert_handler_esc_tx.sv
`default_nettype none
// ============================================================================
// Module   : alert_handler_esc_tx
// Brief    : Escalation sender with ping link test and response integrity check.
// Revision : 1.0
// ============================================================================
module alert_handler_esc_tx #(
    parameter int NPingResp = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    alert_handler_esc_tx_if.slave esc_if
);

    localparam int                 c_CNT_W = (NPingResp > 1) ? $clog2(NPingResp) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NPingResp - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PING_WAIT = 3'd1,
        ST_PING_CHK  = 3'd2,
        ST_ESC_WAIT  = 3'd3,
        ST_ESC_CHK   = 3'd4,
        ST_ESC_DONE  = 3'd5
    } state_e;

    state_e             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tx_p;
    logic               r_ping_ok;
    logic               r_integ_fail;

    logic w_diff_fail;
    logic w_exp_bit;
    logic w_match;

    assign w_diff_fail = (esc_if.esc_rx_p_i == esc_if.esc_rx_n_i);
    // Expected pattern starts at 1 on count 0 and toggles with every count.
    assign w_exp_bit   = ~r_cnt[0];
    assign w_match     = (esc_if.esc_rx_p_i == w_exp_bit);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_tx_p       <= 1'b0;
            r_ping_ok    <= 1'b0;
            r_integ_fail <= 1'b0;
        end else begin
            r_ping_ok    <= 1'b0;
            r_integ_fail <= w_diff_fail;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (esc_if.esc_rx_p_i) begin
                        r_integ_fail <= 1'b1;
                    end
                    if (esc_if.esc_en_i) begin
                        r_state <= ST_ESC_WAIT;
                        r_tx_p  <= 1'b1;
                    end else if (esc_if.ping_en_i) begin
                        r_state <= ST_PING_WAIT;
                        r_tx_p  <= 1'b1;
                    end else begin
                        r_tx_p  <= 1'b0;
                    end
                end
                ST_PING_WAIT: begin
                    r_cnt <= '0;
                    if (esc_if.esc_en_i) begin
                        r_state <= ST_ESC_WAIT;
                        r_tx_p  <= 1'b1;
                    end else begin
                        r_state <= ST_PING_CHK;
                        r_tx_p  <= 1'b0;
                    end
                end
                ST_PING_CHK: begin
                    r_tx_p <= 1'b0;
                    // A differential fault beats the pattern compare, so a
                    // coinciding final match never yields ping_ok.
                    if (esc_if.esc_en_i) begin
                        r_state <= ST_ESC_WAIT;
                        r_tx_p  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_diff_fail) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (!w_match) begin
                        r_state      <= ST_IDLE;
                        r_integ_fail <= 1'b1;
                        r_cnt        <= '0;
                    end else if (r_cnt == c_LAST) begin
                        r_state   <= ST_IDLE;
                        r_ping_ok <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                ST_ESC_WAIT: begin
                    r_state   <= ST_ESC_CHK;
                    r_cnt     <= '0;
                    r_tx_p    <= 1'b1;
                    r_ping_ok <= esc_if.ping_en_i;
                end
                ST_ESC_CHK: begin
                    r_ping_ok <= esc_if.ping_en_i;
                    r_cnt     <= r_cnt + c_ONE;
                    if (!w_diff_fail && !w_match) begin
                        r_integ_fail <= 1'b1;
                    end
                    if (esc_if.esc_en_i) begin
                        r_tx_p  <= 1'b1;
                    end else begin
                        r_state <= ST_ESC_DONE;
                        r_tx_p  <= 1'b0;
                    end
                end
                ST_ESC_DONE: begin
                    r_ping_ok <= esc_if.ping_en_i;
                    r_cnt     <= '0;
                    if (esc_if.esc_en_i) begin
                        r_state <= ST_ESC_WAIT;
                        r_tx_p  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_tx_p  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_tx_p  <= 1'b0;
                end
            endcase
        end
    end

    assign esc_if.esc_tx_p_o   = r_tx_p;
    assign esc_if.esc_tx_n_o   = ~r_tx_p;
    assign esc_if.ping_ok_o    = r_ping_ok;
    assign esc_if.integ_fail_o = r_integ_fail;

endmodule
`default_nettype wire
